// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-serial SRAM port: FSM states,
// func3 size/sign codes and request decode.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Anything we cannot serve is answered with ready+fault and no SRAM cycle.
  function automatic logic is_reject(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (rd && wr)                     bad = 1'b1;
    if (wr && f3[2])                  bad = 1'b1;
    if (f3[1:0] == 2'b11)             bad = 1'b1;
    if (f3[2] && f3[1])               bad = 1'b1;
    if (f3[1:0] == 2'b01 && a[0])     bad = 1'b1;
    if (f3[1:0] == 2'b10 && a != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_if.sv
// Request/response bus between the control unit (master) and mem_port (slave).
interface mem_port_if;
  logic        req_read;
  logic        req_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        ready;
  logic        fault;

  modport master (
    output req_read, req_write, func3, addr, wdata,
    input  rdata, busy, ready, fault
  );

  modport slave (
    input  req_read, req_write, func3, addr, wdata,
    output rdata, busy, ready, fault
  );
endinterface

// File: rtl/load_ext.sv
// Sign/zero extension of a 1, 2 or 4 byte little-endian load to 32 bits.
module load_ext (
  input  logic [31:0] word,
  input  logic [2:0]  nbytes,
  input  logic        is_unsigned,
  output logic [31:0] result
);
  always_comb begin
    result = word;
    case (nbytes)
      3'd1: result = {{24{word[7]  & ~is_unsigned}}, word[7:0]};
      3'd2: result = {{16{word[15] & ~is_unsigned}}, word[15:0]};
      default: result = word;
    endcase
  end
endmodule

// File: rtl/mem_port.sv
// Byte-serial load/store port to an 8-bit asynchronous SRAM with
// programmable wait states; one request at a time.
module mem_port
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_if.slave         bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_dout_en,
  input  logic [7:0]        sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  mem_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       cap_reg;
  logic [31:0]       rdata_reg;
  logic [2:0]        nbytes_reg;
  logic [1:0]        idx_reg;
  logic [3:0]        wait_reg;
  logic              store_reg;
  logic              uns_reg;
  logic              fault_reg;

  logic              req_any;
  logic              reject;
  logic              last_strobe;
  logic [2:0]        idx_inc;
  logic [31:0]       ext_word;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[31:ADDR_W];

  assign req_any     = bus.req_read | bus.req_write;
  assign reject      = is_reject(bus.req_read, bus.req_write, bus.func3, bus.addr[1:0]);
  assign last_strobe = (wait_reg == WAIT_LAST);
  assign idx_inc     = {1'b0, idx_reg} + 3'd1;

  load_ext u_load_ext (
    .word        (cap_reg),
    .nbytes      (nbytes_reg),
    .is_unsigned (uns_reg),
    .result      (ext_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (req_any) state_next = reject ? DONE : SETUP;
      SETUP:  state_next = STROBE;
      STROBE: if (last_strobe) state_next = (idx_inc < nbytes_reg) ? SETUP : DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: request latch, byte/wait counters, capture and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg   <= '0;
      wdata_reg  <= '0;
      cap_reg    <= '0;
      rdata_reg  <= '0;
      nbytes_reg <= 3'd1;
      idx_reg    <= '0;
      wait_reg   <= '0;
      store_reg  <= 1'b0;
      uns_reg    <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (req_any) begin
          addr_reg   <= bus.addr[ADDR_W-1:0];
          wdata_reg  <= bus.wdata;
          cap_reg    <= '0;
          nbytes_reg <= size_bytes(bus.func3[1:0]);
          idx_reg    <= '0;
          wait_reg   <= '0;
          store_reg  <= bus.req_write;
          uns_reg    <= bus.func3[2];
          fault_reg  <= reject;
        end
        SETUP: wait_reg <= '0;
        STROBE: begin
          if (last_strobe) begin
            if (!store_reg) cap_reg[{idx_reg, 3'b000} +: 8] <= sram_din;
            idx_reg  <= idx_reg + 2'd1;
            wait_reg <= '0;
          end else begin
            wait_reg <= wait_reg + 4'd1;
          end
        end
        DONE: if (!store_reg && !fault_reg) rdata_reg <= ext_word;
        default: ;
      endcase
    end
  end

  assign sram_addr = addr_reg + ADDR_W'(idx_reg);
  assign sram_dout = wdata_reg[{idx_reg, 3'b000} +: 8];

  // Strobes decode straight from the state so an async reset drops them at once.
  always_comb begin
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_dout_en = 1'b0;
    bus.ready    = 1'b0;
    bus.fault    = 1'b0;
    bus.busy     = 1'b0;
    bus.rdata    = rdata_reg;
    case (state_reg)
      IDLE:   bus.busy = req_any;
      SETUP: begin
        bus.busy     = 1'b1;
        sram_ce_n    = 1'b0;
        sram_dout_en = store_reg;
      end
      STROBE: begin
        bus.busy     = 1'b1;
        sram_ce_n    = 1'b0;
        sram_dout_en = store_reg;
        sram_oe_n    = store_reg;
        sram_we_n    = ~store_reg;
      end
      DONE: begin
        bus.ready = 1'b1;
        bus.fault = fault_reg;
        if (!store_reg && !fault_reg) bus.rdata = ext_word;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: one DUT with WAIT_CYCLES=1, one with 0,
// each attached to a behavioural 8-bit SRAM.
module tb_mem_port;
  import mem_pkg::*;

  logic clk;
  logic reset;

  mem_port_if b1 ();
  mem_port_if b0 ();

  logic [15:0] addr1, addr0;
  logic [7:0]  dout1, dout0, din1, din0;
  logic        den1, den0, ce1, ce0, oe1, oe0, we1, we0;

  logic [7:0] mem1 [0:65535];
  logic [7:0] mem0 [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  mem_port #(.ADDR_W(16), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave),
    .sram_addr(addr1), .sram_dout(dout1), .sram_dout_en(den1), .sram_din(din1),
    .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1)
  );

  mem_port #(.ADDR_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave),
    .sram_addr(addr0), .sram_dout(dout0), .sram_dout_en(den0), .sram_din(din0),
    .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0)
  );

  assign din1 = (!ce1 && !oe1) ? mem1[addr1] : 8'h00;
  assign din0 = (!ce0 && !oe0) ? mem0[addr0] : 8'h00;

  always @(posedge clk) begin
    if (!ce1 && !we1) mem1[addr1] <= dout1;
    if (!ce0 && !we0) mem0[addr0] <= dout0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=1 port; request held until ready.
  task automatic run1(input string tag, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output int cyc, output logic flt, output logic [31:0] rv,
                      output int we_low, output int ce_low);
    @(negedge clk);
    b1.req_read = rd; b1.req_write = wr; b1.func3 = f3; b1.addr = a; b1.wdata = wd;
    #1 check({tag, " busy_req"}, 32'(b1.busy), 32'd1);
    cyc = -1; flt = 1'b0; rv = '0; we_low = 0; ce_low = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (!ce1) ce_low++;
      if (!we1) we_low++;
      if (b1.ready) begin
        cyc = c; flt = b1.fault; rv = b1.rdata;
        break;
      end
    end
    b1.req_read = 1'b0; b1.req_write = 1'b0;
    $display("txn %s: ready_cycle=%0d fault=%0b rdata=0x%08h we_low=%0d ce_low=%0d",
             tag, cyc, flt, rv, we_low, ce_low);
  endtask

  int          cyc, wl, cl, rdy_seen;
  logic        flt;
  logic [31:0] rv;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem1[i] = 8'h00;
      mem0[i] = 8'h00;
    end
    b1.req_read = 0; b1.req_write = 0; b1.func3 = 0; b1.addr = 0; b1.wdata = 0;
    b0.req_read = 0; b0.req_write = 0; b0.func3 = 0; b0.addr = 0; b0.wdata = 0;
    reset = 1'b1;

    @(negedge clk);
    check("rst rdata",  b1.rdata, 32'h0);
    check("rst busy",   32'(b1.busy), 32'd0);
    check("rst ready",  32'(b1.ready), 32'd0);
    check("rst fault",  32'(b1.fault), 32'd0);
    check("rst strobes", {29'd0, ce1, oe1, we1}, 32'h7);
    check("rst dout_en", 32'(den1), 32'd0);
    check("rst addr",   32'(addr1), 32'h0);
    check("rst dout",   32'(dout1), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run1("SW 0100", 1'b0, 1'b1, F3_W, 32'h0000_0100, 32'h8899_AABB, cyc, flt, rv, wl, cl);
    check("SW cycle", 32'(cyc), 32'd13);
    check("SW fault", 32'(flt), 32'd0);
    check("SW we_n low", 32'(wl), 32'd8);
    check("SW mem", {mem1[16'h103], mem1[16'h102], mem1[16'h101], mem1[16'h100]}, 32'h8899_AABB);

    run1("LB 0103", 1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0, cyc, flt, rv, wl, cl);
    check("LB cycle", 32'(cyc), 32'd4);
    check("LB rdata", rv, 32'hFFFF_FF88);

    run1("LBU 0103", 1'b1, 1'b0, F3_BU, 32'h0000_0103, 32'h0, cyc, flt, rv, wl, cl);
    check("LBU rdata", rv, 32'h0000_0088);
    check("LBU we_n low", 32'(wl), 32'd0);

    run1("LHU 0102", 1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0, cyc, flt, rv, wl, cl);
    check("LHU cycle", 32'(cyc), 32'd7);
    check("LHU rdata", rv, 32'h0000_8899);

    run1("LH 0100", 1'b1, 1'b0, F3_H, 32'h0000_0100, 32'h0, cyc, flt, rv, wl, cl);
    check("LH rdata", rv, 32'hFFFF_AABB);

    run1("LW 0100", 1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, cyc, flt, rv, wl, cl);
    check("LW cycle", 32'(cyc), 32'd13);
    check("LW rdata", rv, 32'h8899_AABB);
    @(negedge clk);
    check("LW rdata held", b1.rdata, 32'h8899_AABB);

    run1("LH 0101 misaligned", 1'b1, 1'b0, F3_H, 32'h0000_0101, 32'h0, cyc, flt, rv, wl, cl);
    check("mis cycle", 32'(cyc), 32'd1);
    check("mis fault", 32'(flt), 32'd1);
    check("mis ce_n low", 32'(cl), 32'd0);
    check("mis rdata", rv, 32'h8899_AABB);

    run1("RD+WR", 1'b1, 1'b1, F3_W, 32'h0000_0100, 32'h1234_5678, cyc, flt, rv, wl, cl);
    check("both cycle", 32'(cyc), 32'd1);
    check("both fault", 32'(flt), 32'd1);
    check("both ce_n low", 32'(cl), 32'd0);
    check("both rdata", rv, 32'h8899_AABB);
    check("both mem", 32'(mem1[16'h100]), 32'h0000_00BB);

    // Store interrupted by reset during its fifth cycle (second byte's strobe).
    @(negedge clk);
    b1.req_write = 1'b1; b1.func3 = F3_W; b1.addr = 32'h0000_0200; b1.wdata = 32'h1122_3344;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    check("rstmid we_n pre", 32'(we1), 32'd0);
    reset = 1'b1;
    b1.req_write = 1'b0;
    #1;
    check("rstmid strobes", {29'd0, ce1, oe1, we1}, 32'h7);
    check("rstmid busy", 32'(b1.busy), 32'd0);
    rdy_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (b1.ready) rdy_seen++;
    end
    reset = 1'b0;
    check("rstmid no ready", 32'(rdy_seen), 32'd0);
    check("rstmid byte0", 32'(mem1[16'h200]), 32'h0000_0044);
    check("rstmid byte1", 32'(mem1[16'h201]), 32'h0000_0000);
    $display("txn SW 0200 reset mid-access: ready_seen=%0d", rdy_seen);

    run1("LW 0100 after reset", 1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, cyc, flt, rv, wl, cl);
    check("LW2 cycle", 32'(cyc), 32'd13);
    check("LW2 rdata", rv, 32'h8899_AABB);

    // WAIT_CYCLES=0: SB then LBU with the request held through DONE.
    @(negedge clk);
    b0.req_write = 1'b1; b0.func3 = F3_B; b0.addr = 32'h0000_0040; b0.wdata = 32'h0000_00A5;
    cyc = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (b0.ready) begin cyc = c; break; end
    end
    check("w0 SB cycle", 32'(cyc), 32'd3);
    check("w0 SB busy done", 32'(b0.busy), 32'd0);
    $display("txn w0 SB 0040: ready_cycle=%0d", cyc);
    b0.req_write = 1'b0; b0.req_read = 1'b1; b0.func3 = F3_BU;
    @(negedge clk);
    check("w0 LBU busy start", 32'(b0.busy), 32'd1);
    check("w0 SB mem", 32'(mem0[16'h40]), 32'h0000_00A5);
    cyc = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (b0.ready) begin cyc = c; break; end
    end
    check("w0 LBU cycle", 32'(cyc), 32'd3);
    check("w0 LBU rdata", b0.rdata, 32'h0000_00A5);
    $display("txn w0 LBU 0040: ready_cycle=%0d rdata=0x%08h", cyc, b0.rdata);
    b0.req_read = 1'b0;
    @(negedge clk);
    check("w0 idle ready", 32'(b0.ready), 32'd0);
    check("w0 rdata held", b0.rdata, 32'h0000_00A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port.md
# mem_port

Byte-serial memory port between the microcoded control unit and an external 8-bit asynchronous SRAM. It accepts one load or store request at a time, using the RISC-V func3 size/sign encoding. Each access is split into 1, 2 or 4 little-endian byte cycles with programmable wait states. `busy` stalls the control state machine until `ready` pulses, and load results are sign- or zero-extended to 32 bits.

## Interface
Parameters:
- `ADDR_W`, 16: external SRAM address width.
- `WAIT_CYCLES`, 1: extra strobe cycles per byte, 0..15.

Ports:
- `clk` in 1: clock, all state changes on rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_read` in 1: load request (control `mem_read`).
- `req_write` in 1: store request (control `mem_write`).
- `func3` in 3: size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- `addr` in 32: byte address, sampled with the request.
- `wdata` in 32: store data, sampled with the request.
- `rdata` out 32: extended load result.
- `busy` out 1: requester must hold its request and stall.
- `ready` out 1: one-cycle completion pulse.
- `fault` out 1: one-cycle pulse with `ready` on a rejected request.
- `sram_addr` out ADDR_W: byte address to the SRAM.
- `sram_dout` out 8: write byte.
- `sram_dout_en` out 1: top level drives the SRAM data pins when high.
- `sram_din` in 8: read byte.
- `sram_ce_n` / `sram_oe_n` / `sram_we_n` out 1 each: active-low strobes.

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- **IDLE**, request seen:
  - Latch `addr`, `func3`, `wdata`; clear byte index i.
  - Set nbytes = 1 / 2 / 4 from `func3[1:0]`.
  - Go to SETUP, or to DONE with `fault` on a reject.
- **Rejects** (no SRAM activity, `rdata` unchanged):
  - `req_read` and `req_write` both high.
  - Store with `func3[2]`=1.
  - `func3` 011 / 11x.
  - Misaligned access: H/HU with `addr[0]`=1, W with `addr[1:0]`≠0.
- **SETUP** (1 cycle):
  - `sram_ce_n`=0; `sram_addr` = `addr[ADDR_W-1:0]` + i, truncated to ADDR_W.
  - On a store: `sram_dout` = byte i of `wdata`, `sram_dout_en`=1.
  - `oe_n` and `we_n` stay high.
- **STROBE** (WAIT_CYCLES+1 cycles):
  - Address and data held; `oe_n`=0 on a load, `we_n`=0 on a store.
  - On the last strobe edge, a load captures `sram_din` into byte lane i.
  - Then i+1. If i+1 < nbytes go to SETUP, else DONE.
- **DONE** (1 cycle):
  - `ready`=1, strobes inactive; next state IDLE.
  - A load updates `rdata`: bits above 8·nbytes are filled with the top captured bit when `func3[2]`=0, else zero.
- A store never changes `rdata`.
- Requests are sampled only in IDLE. A request still asserted in the cycle after DONE starts a new access.
- `busy` = (state≠IDLE && state≠DONE) || (state==IDLE && (req_read||req_write)). It is combinational, so the control unit stalls in the request cycle itself.

## Timing
- Request in cycle 0, accepted at the cycle-0 edge.
- `ready` rises in cycle 1 + nbytes·(WAIT_CYCLES+2).
- With WAIT_CYCLES=1: byte access = cycle 4, half = cycle 7, word = cycle 13.
- A rejected request gives `ready`+`fault` in cycle 1.
- `rdata` is valid from the DONE cycle onward and held until the next successful load.
- Reset values:
  - State IDLE; `rdata`, `sram_addr`, `sram_dout` = 0.
  - `ready`, `fault`, `busy`, `sram_dout_en` = 0.
  - `sram_ce_n` / `oe_n` / `we_n` = 1.
- Reset mid-access:
  - Strobes deassert immediately (asynchronously) and no `ready` is produced.
  - Bytes already written by a partial store remain in the SRAM.
- Alignment rules guarantee that no access crosses the ADDR_W wrap.

## Structure
- Package `mem_pkg`: func3 size/sign constants and the `mem_state_t` enum (IDLE, SETUP, STROBE, DONE).
- Sub-module `load_ext`: combinational extension (captured word, nbytes, unsigned) -> 32-bit result.
- Top-level RTL: FSM, byte index counter, wait counter, capture register.

## Test plan
- Store word, WAIT_CYCLES=1: SW `addr`=0x0100, `wdata`=0x8899AABB -> SRAM 0x100..0x103 = BB,AA,99,88; `we_n` low 2 cycles per byte; `ready` in cycle 13.
- Byte loads after that store:
  - LB 0x0103 -> `rdata`=0xFFFFFF88, `ready` in cycle 4.
  - LBU 0x0103 -> 0x00000088.
- Half loads:
  - LHU 0x0102 -> 0x00008899.
  - LH 0x0100 -> 0xFFFFAABB.
  - LW 0x0100 -> 0x8899AABB, `ready` in cycle 13.
- Rejects:
  - LH 0x0101 -> `ready`=`fault`=1 in cycle 1, `sram_ce_n` never low, `rdata` unchanged.
  - Simultaneous `req_read`+`req_write` -> same response.
- Reset during cycle 5 of an SW -> strobes high the same cycle, no `ready`, `busy`=0. A following LW completes normally.
- WAIT_CYCLES=0 back-to-back: SB then LBU with the request held through DONE -> second access starts the cycle after DONE; `ready` in cycle 3 for each byte access.
